multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control unit for the RISC core. It decodes the latched instruction type/opcode fields and sequences the shared datapath through fetch, decode, execute, memory and write-back states, emitting one-hot-per-cycle strobes for the IR, PC, register file and data memory. It sits between the instruction register and the datapath in the multi-cycle top and replaces the purely combinational decode of the one-cycle core.

## Interface
- RETIRE_W, 16, width of the retired-instruction counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- run  in  1  fetch enable; sampled only in FETCH
- instr_t  in  2  IR[31:30]; 10 logic, 11 arithmetic, 00 movement, 01 flow control
- instr_opc  in  3  IR[29:27]
- flag_z  in  1  zero flag of the last ALU result
- flag_c  in  1  carry flag (result bit 32)
- flag_v  in  1  overflow flag (result bit 33)
- mem_ack  in  1  data memory completion; may assert in the first request cycle
- ir_we  out  1  load IR from instruction memory at PC
- ab_we  out  1  latch register operands B/C
- alu_en  out  1  ALU result register load
- reg_we  out  1  register file write to RA
- wb_sel  out  2  00 ALU, 01 memory, 10 immediate, 11 link (PC+4)
- pc_we  out  1  PC load
- pc_src  out  2  00 PC+4, 01 PC+(imm<<2), 10 register RC, 11 link register
- mem_req  out  1  data memory request
- mem_we  out  1  1 = store, valid while mem_req
- state  out  3  current state code (debug)
- illegal  out  1  illegal-opcode indication
- retired  out  RETIRE_W  instructions completed since reset

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Outputs are Moore-decoded from state plus the instr_t/instr_opc fields; IR is stable from DECODE onward.
- FETCH: run=1 -> ir_we=1, go DECODE; run=0 -> all strobes 0, stay.
- DECODE: ab_we=1, go EXEC.
- EXEC, logic (OPC 000 OR, 001 INV, 010 AND) or arithmetic (000 ADDC, 001 SUBC, 010 ADD, 011 SUB): alu_en=1, go WB with wb_sel=00.
- EXEC, movement: 000 LOAD, 001 STORE -> go MEM; 010 LOADI -> go WB, wb_sel=10; 011 STOREI -> go MEM; 100 MOV -> go WB, wb_sel=00 (ALU pass-through, alu_en=1).
- EXEC, flow: 000 JUMP taken; 001 BZ if flag_z; 010 BNZ if !flag_z; 011 BC if flag_c; 100 BV if flag_v; 101 JAL taken plus reg_we, wb_sel=11; 110 JRAL pc_src=10 plus reg_we, wb_sel=11; 111 RET pc_src=11. pc_we=1 always (taken -> target source, not taken -> 00); go FETCH; instruction retires.
- MEM: mem_req=1, mem_we=1 for STORE/STOREI. mem_req, mem_we held constant until mem_ack. On ack: LOAD -> WB with wb_sel=01; stores -> pc_we=1, pc_src=00, retire, go FETCH.
- WB: reg_we=1, pc_we=1, pc_src=00, retire, go FETCH.
- Reserved encodings (logic OPC 011-111, arithmetic 100-111, movement 101-111) are illegal; handling per Configuration.
- retired increments by 1 on every retire cycle; wraps from 2^RETIRE_W-1 to 0 with no flag.

## Timing
- Reset: state=FETCH, retired=0, illegal=0; while rst=1 all strobes are forced to 0. rst overrides every state, including MEM with an outstanding request: mem_req drops in the cycle after rst is sampled, and no write/PC update occurs.
- Latency: ALU/LOADI/MOV 4 cycles (F,D,E,WB); flow 3 (F,D,E); STORE 3+N; LOAD 4+N, where N≥1 is MEM cycles up to and including ack.
- Exactly one pc_we and at most one reg_we per instruction; never pc_we and ir_we in the same cycle.
- Flags are sampled in EXEC only; flag changes in other states have no effect.
- mem_ack outside MEM is ignored.
- Deasserting run mid-instruction does not stall; it takes effect at the next FETCH.

## Configuration
- MULTICYCLE_CTRL_TRAP_EN defined: an illegal encoding in EXEC -> TRAP; illegal=1, all strobes 0, no retire; TRAP is left only by rst.
- Undefined: illegal encodings execute as NOP: EXEC goes to WB with reg_we suppressed, pc_we=1, pc_src=00, retire counted; illegal is tied to 0 and state 5 is unreachable.

## Test plan
- Reset then run=1, IR=ADD (T=11, OPC=010): states 0,1,2,4,0; reg_we=1 and pc_we=1 only in WB; retired=1.
- LOAD with mem_ack delayed 3 cycles: mem_req high for exactly 3 cycles; WB with wb_sel=01; total 7 cycles; retired +1.
- BZ with flag_z=0, then with flag_z=1: EXEC pc_src=00, then pc_src=01; both pc_we=1; no reg_we; 3 cycles each.
- JAL then RET: JAL EXEC reg_we=1, wb_sel=11, pc_src=01; RET EXEC pc_src=11, reg_we=0.
- rst asserted during MEM of a STORE with mem_ack low: next cycle state=0, mem_req=0, retired=0, no pc_we.
- Logic OPC=111: with TRAP_EN, state=5, illegal=1, stays there for 10 cycles; without it, pc_we=1, pc_src=00, retired +1. Separately, preload retired to 0xFFFF and retire one instruction: retired reads 0x0000.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the RISC core.
// It sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and Moore-decodes
// the datapath strobes from the current state and the latched IR fields.
// Optional build macro: MULTICYCLE_CTRL_TRAP_EN. When it is defined, reserved
// encodings trap. When it is not defined, reserved encodings execute as NOPs.
module multicycle_ctrl #(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [1:0]          instr_t,
  input  logic [2:0]          instr_opc,
  input  logic                flag_z,
  input  logic                flag_c,
  input  logic                flag_v,
  input  logic                mem_ack,
  output logic                ir_we,
  output logic                ab_we,
  output logic                alu_en,
  output logic                reg_we,
  output logic [1:0]          wb_sel,
  output logic                pc_we,
  output logic [1:0]          pc_src,
  output logic                mem_req,
  output logic                mem_we,
  output logic [2:0]          state,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [1:0] T_MOVE  = 2'b00;
  localparam logic [1:0] T_FLOW  = 2'b01;
  localparam logic [1:0] T_LOGIC = 2'b10;
  localparam logic [1:0] T_ARITH = 2'b11;

  state_e              state_q, state_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  logic       ir_we_s, ab_we_s, alu_en_s, reg_we_s, pc_we_s;
  logic       mem_req_s, mem_we_s, retire_s;
  logic [1:0] wb_sel_s, pc_src_s;
  logic       is_alu_s, is_mov_s, is_load_s, is_store_s, is_loadi_s;
  logic       is_flow_s, is_ill_s, taken_s;

  // Classify the latched instruction fields into execution classes
  always_comb begin
    is_alu_s   = 1'b0;
    is_mov_s   = 1'b0;
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    is_loadi_s = 1'b0;
    is_flow_s  = 1'b0;
    case (instr_t)
      T_LOGIC: is_alu_s = (instr_opc <= 3'd2);
      T_ARITH: is_alu_s = (instr_opc <= 3'd3);
      T_MOVE: begin
        case (instr_opc)
          3'd0:    is_load_s  = 1'b1;
          3'd1:    is_store_s = 1'b1;
          3'd2:    is_loadi_s = 1'b1;
          3'd3:    is_store_s = 1'b1;
          3'd4:    is_mov_s   = 1'b1;
          default: is_mov_s   = 1'b0;
        endcase
      end
      T_FLOW:  is_flow_s = 1'b1;
      default: is_flow_s = 1'b0;
    endcase
    is_ill_s = ~(is_alu_s | is_mov_s | is_load_s | is_store_s | is_loadi_s | is_flow_s);
  end

  // Branch condition for flow-control opcodes, evaluated from the live flags
  always_comb begin
    case (instr_opc)
      3'd0:    taken_s = 1'b1;
      3'd1:    taken_s = flag_z;
      3'd2:    taken_s = ~flag_z;
      3'd3:    taken_s = flag_c;
      3'd4:    taken_s = flag_v;
      3'd5:    taken_s = 1'b1;
      default: taken_s = 1'b0;
    endcase
  end

  // Next-state and Moore strobe decode
  always_comb begin
    state_d   = state_q;
    ir_we_s   = 1'b0;
    ab_we_s   = 1'b0;
    alu_en_s  = 1'b0;
    reg_we_s  = 1'b0;
    wb_sel_s  = 2'b00;
    pc_we_s   = 1'b0;
    pc_src_s  = 2'b00;
    mem_req_s = 1'b0;
    mem_we_s  = 1'b0;
    retire_s  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (run) begin
          ir_we_s = 1'b1;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        ab_we_s = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_flow_s) begin
          pc_we_s  = 1'b1;
          retire_s = 1'b1;
          state_d  = S_FETCH;
          case (instr_opc)
            3'd5: begin
              pc_src_s = 2'b01;
              reg_we_s = 1'b1;
              wb_sel_s = 2'b11;
            end
            3'd6: begin
              pc_src_s = 2'b10;
              reg_we_s = 1'b1;
              wb_sel_s = 2'b11;
            end
            3'd7:    pc_src_s = 2'b11;
            default: pc_src_s = taken_s ? 2'b01 : 2'b00;
          endcase
        end else if (is_alu_s || is_mov_s) begin
          alu_en_s = 1'b1;
          state_d  = S_WB;
        end else if (is_load_s || is_store_s) begin
          state_d = S_MEM;
        end else if (is_loadi_s) begin
          state_d = S_WB;
        end else begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_WB;
`endif
        end
      end
      S_MEM: begin
        mem_req_s = 1'b1;
        mem_we_s  = is_store_s;
        if (mem_ack && is_store_s) begin
          pc_we_s  = 1'b1;
          retire_s = 1'b1;
          state_d  = S_FETCH;
        end else if (mem_ack) begin
          state_d = S_WB;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        reg_we_s = ~is_ill_s;
        wb_sel_s = is_load_s ? 2'b01 : (is_loadi_s ? 2'b10 : 2'b00);
        pc_we_s  = 1'b1;
        retire_s = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
        state_d = S_TRAP;
`else
        state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Retire counter next value; wraps silently
  always_comb begin
    if (retire_s && !rst) begin
      retired_d = retired_q + {{(RETIRE_W-1){1'b0}}, 1'b1};
    end else begin
      retired_d = retired_q;
    end
  end

  // State and retire counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Reset forces every strobe low regardless of state
  assign ir_we   = ir_we_s   & ~rst;
  assign ab_we   = ab_we_s   & ~rst;
  assign alu_en  = alu_en_s  & ~rst;
  assign reg_we  = reg_we_s  & ~rst;
  assign pc_we   = pc_we_s   & ~rst;
  assign mem_req = mem_req_s & ~rst;
  assign mem_we  = mem_we_s  & ~rst;
  assign wb_sel  = rst ? 2'b00 : wb_sel_s;
  assign pc_src  = rst ? 2'b00 : pc_src_s;
  assign state   = state_q;
  assign retired = retired_q;

`ifdef MULTICYCLE_CTRL_TRAP_EN
  assign illegal = (state_q == S_TRAP);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: each instruction is expanded into
// its expected cycle script, and one negedge process compares every cycle.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, run, flag_z, flag_c, flag_v, mem_ack;
  logic [1:0] instr_t;
  logic [2:0] instr_opc;

  logic        ir_we, ab_we, alu_en, reg_we, pc_we, mem_req, mem_we, illegal;
  logic [1:0]  wb_sel, pc_src;
  logic [2:0]  state;
  logic [15:0] retired;

  logic       w_ir_we, w_ab_we, w_alu_en, w_reg_we, w_pc_we, w_mem_req, w_mem_we, w_illegal;
  logic [1:0] w_wb_sel, w_pc_src;
  logic [2:0] w_state;
  logic [2:0] w_retired;

  multicycle_ctrl #(.RETIRE_W(16)) dut (
    .clk(clk), .rst(rst), .run(run), .instr_t(instr_t), .instr_opc(instr_opc),
    .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .mem_ack(mem_ack),
    .ir_we(ir_we), .ab_we(ab_we), .alu_en(alu_en), .reg_we(reg_we), .wb_sel(wb_sel),
    .pc_we(pc_we), .pc_src(pc_src), .mem_req(mem_req), .mem_we(mem_we),
    .state(state), .illegal(illegal), .retired(retired)
  );

  // Narrow counter instance: exercises the retire-counter wrap in few cycles
  multicycle_ctrl #(.RETIRE_W(3)) dut_w (
    .clk(clk), .rst(rst), .run(run), .instr_t(instr_t), .instr_opc(instr_opc),
    .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .mem_ack(mem_ack),
    .ir_we(w_ir_we), .ab_we(w_ab_we), .alu_en(w_alu_en), .reg_we(w_reg_we), .wb_sel(w_wb_sel),
    .pc_we(w_pc_we), .pc_src(w_pc_src), .mem_req(w_mem_req), .mem_we(w_mem_we),
    .state(w_state), .illegal(w_illegal), .retired(w_retired)
  );

  typedef struct packed {
    logic       ir_we;
    logic       ab_we;
    logic       alu_en;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       mem_req;
    logic       mem_we;
    logic [2:0] state;
    logic       illegal;
  } exp_t;

  typedef enum int {K_ALU, K_MOV, K_LOAD, K_STORE, K_LOADI, K_FLOW, K_ILL} kind_e;

  exp_t        e;
  logic        chk_en;
  logic        pend_retire;
  logic [31:0] m_retired;
  int          n_checks = 0;
  int          n_errors = 0;

  logic        pin_en;
  int          pin_kind;
  logic [31:0] pin_exp;
  string       pin_name;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Single compare process: DUT vs model every checked cycle, plus literal pins
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("state",   32'(state),   32'(e.state));
      cmp("ir_we",   32'(ir_we),   32'(e.ir_we));
      cmp("ab_we",   32'(ab_we),   32'(e.ab_we));
      cmp("alu_en",  32'(alu_en),  32'(e.alu_en));
      cmp("reg_we",  32'(reg_we),  32'(e.reg_we));
      cmp("pc_we",   32'(pc_we),   32'(e.pc_we));
      cmp("mem_req", 32'(mem_req), 32'(e.mem_req));
      cmp("illegal", 32'(illegal), 32'(e.illegal));
      cmp("retired", 32'(retired), {16'd0, m_retired[15:0]});
      cmp("retired_narrow", 32'(w_retired), {29'd0, m_retired[2:0]});
      if (e.reg_we)  cmp("wb_sel", 32'(wb_sel), 32'(e.wb_sel));
      if (e.pc_we)   cmp("pc_src", 32'(pc_src), 32'(e.pc_src));
      if (e.mem_req) cmp("mem_we", 32'(mem_we), 32'(e.mem_we));
    end
    if (pin_en) begin
      case (pin_kind)
        0:       cmp(pin_name, 32'(retired), pin_exp);
        1:       cmp(pin_name, 32'(state), pin_exp);
        2:       cmp(pin_name, m_retired, pin_exp);
        default: cmp(pin_name, 32'(w_retired), pin_exp);
      endcase
    end
  end

  function automatic kind_e classify(input logic [1:0] t, input logic [2:0] opc);
    case (t)
      2'b10: return (opc <= 3'd2) ? K_ALU : K_ILL;
      2'b11: return (opc <= 3'd3) ? K_ALU : K_ILL;
      2'b01: return K_FLOW;
      default: begin
        case (opc)
          3'd0:    return K_LOAD;
          3'd1:    return K_STORE;
          3'd2:    return K_LOADI;
          3'd3:    return K_STORE;
          3'd4:    return K_MOV;
          default: return K_ILL;
        endcase
      end
    endcase
  endfunction

  // Advance one cycle; update the model counter from the cycle just ended
  task automatic step();
    @(posedge clk);
    #1;
    if (rst) m_retired = 32'd0;
    else if (pend_retire) m_retired = m_retired + 32'd1;
    pend_retire = 1'b0;
    pin_en  = 1'b0;
    e       = '0;
    run     = 1'b0;
    flag_z  = 1'($urandom);
    flag_c  = 1'($urandom);
    flag_v  = 1'($urandom);
    mem_ack = 1'($urandom);
  endtask

  task automatic pin(input int kind, input string name, input logic [31:0] v);
    pin_en   = 1'b1;
    pin_kind = kind;
    pin_name = name;
    pin_exp  = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      e.state = 3'd0;
    end
  endtask

  // Expand one instruction into its expected cycle script
  task automatic do_instr(input logic [1:0] t, input logic [2:0] opc,
                          input logic fz, input logic fc, input logic fv,
                          input int ack_n, input int rst_at);
    kind_e k;
    logic  tk;
    k = classify(t, opc);
    step();
    run = 1'b1; instr_t = t; instr_opc = opc;
    e.state = 3'd0; e.ir_we = 1'b1;
    step();
    e.state = 3'd1; e.ab_we = 1'b1;
    step();
    e.state = 3'd2;
    flag_z = fz; flag_c = fc; flag_v = fv;
    if (k == K_FLOW) begin
      tk = (opc == 3'd0) || (opc == 3'd5) || (opc == 3'd1 && fz) ||
           (opc == 3'd2 && !fz) || (opc == 3'd3 && fc) || (opc == 3'd4 && fv);
      e.pc_we  = 1'b1;
      e.pc_src = (opc == 3'd6) ? 2'b10 : (opc == 3'd7) ? 2'b11 : (tk ? 2'b01 : 2'b00);
      e.reg_we = (opc == 3'd5) || (opc == 3'd6);
      e.wb_sel = 2'b11;
      pend_retire = 1'b1;
      return;
    end
    if (k == K_ALU || k == K_MOV) e.alu_en = 1'b1;
`ifdef MULTICYCLE_CTRL_TRAP_EN
    if (k == K_ILL) begin
      for (int i = 0; i < 10; i++) begin
        step();
        e.state = 3'd5; e.illegal = 1'b1;
      end
      pin(1, "trap_state", 32'd5);
      return;
    end
`endif
    if (k == K_LOAD || k == K_STORE) begin
      for (int i = 1; i <= ack_n; i++) begin
        step();
        e.state = 3'd3;
        mem_ack = 1'b0;
        if (i == rst_at) begin
          rst = 1'b1;
          return;
        end
        e.mem_req = 1'b1;
        e.mem_we  = (k == K_STORE);
        mem_ack   = (i == ack_n);
        if (i == ack_n && k == K_STORE) begin
          e.pc_we = 1'b1; e.pc_src = 2'b00;
          pend_retire = 1'b1;
          return;
        end
      end
    end
    step();
    e.state  = 3'd4;
    e.reg_we = (k != K_ILL);
    e.wb_sel = (k == K_LOAD) ? 2'b01 : (k == K_LOADI) ? 2'b10 : 2'b00;
    e.pc_we  = 1'b1; e.pc_src = 2'b00;
    pend_retire = 1'b1;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; instr_t = 2'b00; instr_opc = 3'd0;
    flag_z = 1'b0; flag_c = 1'b0; flag_v = 1'b0; mem_ack = 1'b0;
    chk_en = 1'b0; pend_retire = 1'b0; m_retired = 32'd0; e = '0;
    pin_en = 1'b0; pin_kind = 0; pin_exp = 32'd0; pin_name = "";
    step();
    rst = 1'b1;
    step();
    rst = 1'b1; chk_en = 1'b1; e.state = 3'd0;
    pin(0, "reset_retired", 32'd0);
    step();
    e.state = 3'd0; rst = 1'b0;
    idle(3);

    do_instr(2'b11, 3'd2, 1'b0, 1'b0, 1'b0, 0, 0);            // ADD
    step(); e.state = 3'd0; pin(0, "add_retired", 32'd1);
    do_instr(2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 3, 0);            // LOAD, ack after 3
    step(); e.state = 3'd0; pin(2, "model_retired_after_load", 32'd2);
    do_instr(2'b01, 3'd1, 1'b0, 1'b0, 1'b0, 0, 0);            // BZ not taken
    do_instr(2'b01, 3'd1, 1'b1, 1'b0, 1'b0, 0, 0);            // BZ taken
    do_instr(2'b01, 3'd5, 1'b0, 1'b0, 1'b0, 0, 0);            // JAL
    do_instr(2'b01, 3'd7, 1'b0, 1'b0, 1'b0, 0, 0);            // RET
    do_instr(2'b00, 3'd1, 1'b0, 1'b0, 1'b0, 1, 0);            // STORE, ack in first cycle
    do_instr(2'b00, 3'd3, 1'b0, 1'b0, 1'b0, 2, 0);            // STOREI
    do_instr(2'b00, 3'd2, 1'b0, 1'b0, 1'b0, 0, 0);            // LOADI
    do_instr(2'b00, 3'd4, 1'b0, 1'b0, 1'b0, 0, 0);            // MOV
    do_instr(2'b10, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);            // OR
    do_instr(2'b10, 3'd1, 1'b0, 1'b0, 1'b0, 0, 0);            // INV
    do_instr(2'b11, 3'd1, 1'b0, 1'b0, 1'b0, 0, 0);            // SUBC
    do_instr(2'b01, 3'd2, 1'b1, 1'b0, 1'b0, 0, 0);            // BNZ not taken
    do_instr(2'b01, 3'd3, 1'b0, 1'b1, 1'b0, 0, 0);            // BC taken
    do_instr(2'b01, 3'd4, 1'b0, 1'b1, 1'b0, 0, 0);            // BV not taken
    do_instr(2'b01, 3'd6, 1'b0, 1'b0, 1'b0, 0, 0);            // JRAL
    do_instr(2'b01, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);            // JUMP
    step(); e.state = 3'd0; pin(0, "retired_18", 32'd18);
    do_instr(2'b10, 3'd7, 1'b0, 1'b0, 1'b0, 0, 0);            // reserved logic opcode
`ifdef MULTICYCLE_CTRL_TRAP_EN
    step(); e.state = 3'd5; e.illegal = 1'b1;
    pin(0, "trap_no_retire", 32'd18);
    step(); rst = 1'b1; chk_en = 1'b0;
    step(); rst = 1'b0; chk_en = 1'b1; e.state = 3'd0;
    pin(0, "retired_after_trap_reset", 32'd0);
`else
    step(); e.state = 3'd0; pin(0, "nop_retired", 32'd19);
    step(); e.state = 3'd0; pin(3, "narrow_wrapped", 32'd3);
`endif

    do_instr(2'b00, 3'd1, 1'b0, 1'b0, 1'b0, 5, 2);            // STORE, rst in 2nd MEM cycle
    step(); e.state = 3'd0; rst = 1'b0;
    pin(0, "rst_in_mem_retired", 32'd0);
    idle(2);
    do_instr(2'b11, 3'd3, 1'b0, 1'b0, 1'b0, 0, 0);            // SUB
    step(); e.state = 3'd0; pin(0, "retired_after_sub", 32'd1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
